// File: rtl/proc_ctrl_seq_pkg.sv
// Shared definitions for the bus-processor control sequencer: opcodes, ALU codes,
// FSM state encoding and the PC register index.
package proc_ctrl_seq_pkg;

  localparam logic [3:0] OP_MV   = 4'b0000;
  localparam logic [3:0] OP_ST   = 4'b0001;
  localparam logic [3:0] OP_MVNZ = 4'b0010;
  localparam logic [3:0] OP_LD   = 4'b0011;
  localparam logic [3:0] OP_MVI  = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;

  localparam logic [2:0] PC_IDX = 3'd7;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitI,
    StEx1,
    StEx2,
    StEx3,
    StWaitD,
    StWaitW
  } state_e;

  function automatic logic [2:0] alu_op_of(input logic [3:0] op);
    logic [2:0] code;
    case (op)
      OP_SUB:  code = ALU_SUB;
      OP_OR:   code = ALU_OR;
      OP_SLT:  code = ALU_SLT;
      OP_SLL:  code = ALU_SLL;
      OP_SRL:  code = ALU_SRL;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/proc_ctrl_seq_dec3to8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module dec3to8 (
  input  logic [2:0] w_i,
  input  logic       en_i,
  output logic [7:0] y_o
);

  always_comb begin
    y_o = '0;
    if (en_i) y_o[w_i] = 1'b1;
  end

endmodule

// File: rtl/proc_ctrl_seq.sv
// Multi-cycle control sequencer for the 16-bit bus processor: fetch, decode, execute,
// with a ready handshake and timeout on every memory wait.
module proc_ctrl_seq
  import proc_ctrl_seq_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Run,
  input  logic [9:0] IR,
  input  logic       g_nz,
  input  logic       mem_rdy,
  output logic [7:0] reg_out,
  output logic       din_out,
  output logic       g_out,
  output logic [7:0] reg_in,
  output logic       a_in,
  output logic       g_in,
  output logic       ir_in,
  output logic       addr_in,
  output logic       dout_in,
  output logic       w_en,
  output logic       incr_pc,
  output logic [2:0] alu_op,
  output logic       done,
  output logic       err
);

  localparam logic [7:0] WaitLimit = 8'(WAIT_LIMIT);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] x_oh, y_oh;
  logic [3:0] opcode;
  logic       in_wait, timeout;

  assign opcode = IR[9:6];

  dec3to8 u_dec_x (
    .w_i (IR[5:3]),
    .en_i(1'b1),
    .y_o (x_oh)
  );

  dec3to8 u_dec_y (
    .w_i (IR[2:0]),
    .en_i(1'b1),
    .y_o (y_oh)
  );

  assign in_wait = state_q inside {StWaitI, StWaitD, StWaitW};
  assign timeout = in_wait && (wait_cnt_q == WaitLimit);

  // Counter is held at zero outside the wait states, so every wait entry starts fresh.
  always_comb begin
    wait_cnt_d = '0;
    if (in_wait) begin
      wait_cnt_d = (mem_rdy || timeout) ? wait_cnt_q : wait_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    reg_out = '0;
    din_out = 1'b0;
    g_out   = 1'b0;
    reg_in  = '0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    ir_in   = 1'b0;
    addr_in = 1'b0;
    dout_in = 1'b0;
    w_en    = 1'b0;
    incr_pc = 1'b0;
    alu_op  = '0;
    done    = 1'b0;
    err     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Run) state_d = StFetch;
      end
      StFetch: begin
        reg_out[PC_IDX] = 1'b1;
        addr_in         = 1'b1;
        incr_pc         = 1'b1;
        state_d         = StWaitI;
      end
      StWaitI: begin
        if (timeout) begin
          done = 1'b1;
          err  = 1'b1;
        end else if (mem_rdy) begin
          ir_in   = 1'b1;
          state_d = StEx1;
        end
      end
      StEx1: begin
        case (opcode)
          OP_MV: begin
            reg_out = y_oh;
            reg_in  = x_oh;
            done    = 1'b1;
          end
          OP_MVNZ: begin
            if (g_nz) begin
              reg_out = y_oh;
              reg_in  = x_oh;
            end
            done = 1'b1;
          end
          OP_MVI: begin
            reg_out[PC_IDX] = 1'b1;
            addr_in         = 1'b1;
            incr_pc         = 1'b1;
            state_d         = StWaitD;
          end
          OP_LD: begin
            reg_out = y_oh;
            addr_in = 1'b1;
            state_d = StWaitD;
          end
          OP_ST: begin
            reg_out = y_oh;
            addr_in = 1'b1;
            state_d = StEx2;
          end
          OP_ADD, OP_SUB, OP_OR, OP_SLT, OP_SLL, OP_SRL: begin
            reg_out = x_oh;
            a_in    = 1'b1;
            state_d = StEx2;
          end
          default: begin
            done = 1'b1;
            err  = 1'b1;
          end
        endcase
      end
      StEx2: begin
        if (opcode == OP_ST) begin
          reg_out = x_oh;
          dout_in = 1'b1;
          state_d = StWaitW;
        end else begin
          reg_out = y_oh;
          g_in    = 1'b1;
          alu_op  = alu_op_of(opcode);
          state_d = StEx3;
        end
      end
      StEx3: begin
        g_out  = 1'b1;
        reg_in = x_oh;
        done   = 1'b1;
      end
      StWaitD: begin
        if (timeout) begin
          done = 1'b1;
          err  = 1'b1;
        end else if (mem_rdy) begin
          din_out = 1'b1;
          reg_in  = x_oh;
          done    = 1'b1;
        end
      end
      StWaitW: begin
        w_en = 1'b1;
        if (timeout) begin
          done = 1'b1;
          err  = 1'b1;
        end else if (mem_rdy) begin
          done = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (done) state_d = Run ? StFetch : StIdle;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: doc/proc_ctrl_seq.md
Name: proc_ctrl_seq

Overview:
Multi-cycle control sequencer for the 16-bit bus processor datapath (R0..R7 with R7 as PC, A, G, IR, shared bus mux, ALU).
- Fetches each instruction from memory through the address register and decodes the 4-bit opcode in IR[9:6].
- Drives every datapath enable, including bus-source selects, register loads, ALU op, PC increment and memory strobes.
- Handles variable-latency memory via a ready handshake with a timeout.

Parameters:
WAIT_LIMIT, 255, max cycles spent in any memory-wait state before abort (1..255).

Ports:
Clock  in  1  system clock, rising edge
Resetn  in  1  asynchronous active-low reset
Run  in  1  level; 1 = execute instructions continuously
IR  in  10  instruction register contents: opcode[9:6], X[5:3], Y[2:0]
g_nz  in  1  1 when G != 0 (for mvnz)
mem_rdy  in  1  memory read data valid / write accepted, this cycle
reg_out  out  8  one-hot bus source select R0..R7 (bit i = Ri)
din_out  out  1  DIN drives bus
g_out  out  1  G drives bus
reg_in  out  8  one-hot register load R0..R7
a_in  out  1  load A from bus
g_in  out  1  load G from ALU
ir_in  out  1  load IR from DIN
addr_in  out  1  load memory address register from bus
dout_in  out  1  load memory data-out register from bus
w_en  out  1  memory write strobe
incr_pc  out  1  increment R7
alu_op  out  3  000 add, 001 sub, 010 or, 011 slt, 100 sll, 101 srl
done  out  1  one-cycle pulse in last cycle of each instruction
err  out  1  one-cycle pulse with done: illegal opcode or memory timeout

Behaviour:
- Outputs are combinational from the registered state, the latched IR and mem_rdy.
- All outputs are 0 in IDLE and while Resetn=0. Reset mid-instruction forces IDLE and clears the wait counter.
- Bus exclusivity invariant: at most one of reg_out bits, din_out and g_out is high in any cycle.
- States: IDLE, FETCH, WAITI, EX1, EX2, EX3, WAITD, WAITW.
- IDLE: Run=1 -> FETCH.
- FETCH: reg_out[7], addr_in, incr_pc -> WAITI.
- WAITI: on mem_rdy assert ir_in -> EX1; otherwise stay.
- EX1, by opcode:
  - mv 0000: reg_out=Y, reg_in=X, done.
  - mvnz 0010: same as mv only if g_nz=1, else no enables; done either way.
  - mvi 0100: reg_out[7], addr_in, incr_pc -> WAITD.
  - ld 0011: reg_out=Y, addr_in -> WAITD.
  - st 0001: reg_out=Y, addr_in -> EX2.
  - add/sub/or/slt/sll/srl 0101..1010: reg_out=X, a_in -> EX2.
  - 1011..1111: done, err, no other enables.
- EX2:
  - ALU ops: reg_out=Y, g_in, alu_op per opcode -> EX3.
  - st: reg_out=X, dout_in -> WAITW.
- EX3: g_out, reg_in=X, done.
- WAITD: on mem_rdy assert din_out, reg_in=X, done.
- WAITW: w_en held high; on mem_rdy assert done.
- Timeout: an 8-bit counter clears on entering WAITI, WAITD or WAITW and increments each cycle mem_rdy=0.
  - When it reaches WAIT_LIMIT: done=1, err=1, no register load; WAITI timeout does not assert ir_in.
- After a done cycle the next state is FETCH if Run=1, else IDLE.
  - Run falling mid-instruction does not abort; the instruction completes.
- Latency with mem_rdy tied 1: mv/mvnz/illegal 3 cycles, mvi/ld 4, ALU ops 5, st 5 (FETCH through done inclusive).
- Destination X=7 (write to PC) is legal. incr_pc and reg_in[7] are never both high in one cycle.

Decomposition:
- Shared package holds:
  - opcode constants (OP_MV..OP_SRL);
  - ALU op codes;
  - state encoding;
  - the R7 PC index.
- One sub-module: dec3to8 (existing 3-to-8 decoder with enable), instantiated twice for the X and Y one-hot fields.

Test Plan:
1. Resetn=0 with Run=1, then release; IR=0000_010_101 (mv R2,R5), mem_rdy=1 -> FETCH: reg_out=8'h80, addr_in=1, incr_pc=1; WAITI: ir_in; EX1: reg_out bit5, reg_in bit2, done=1; next FETCH.
2. add R1,R3 (0101_001_011), mem_rdy=1 -> EX1: reg_out bit1, a_in; EX2: reg_out bit3, g_in, alu_op=000; EX3: g_out, reg_in bit1, done. Repeat for srl -> alu_op=101.
3. mvnz R4,R0 with g_nz=0 -> done in EX1, reg_in=0; with g_nz=1 -> reg_in bit4, reg_out bit0.
4. ld R6,R2 with mem_rdy low for 3 cycles in WAITD -> din_out, reg_in bit6 and done exactly on the first mem_rdy=1 cycle.
5. st R3,R1 with mem_rdy=1 -> addr_in with reg_out bit1, then dout_in with reg_out bit3, then w_en and done; no reg_in asserted.
6. Cases:
   - opcode 1100 -> done=1 and err=1 in EX1.
   - WAIT_LIMIT=4 with mem_rdy held 0 in WAITI -> done and err after 4 wait cycles, ir_in never high.
   - Resetn pulse in WAITW -> all outputs 0 immediately; IDLE after release.
